// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bus between the EX-stage control/operand logic
// (master) and the sequential ALU (slave).
//   Request : in_valid, in_ready, aluco, aluin1, aluin2, alu_shift
//   Response: out_valid, out_ready, aluout, aluout_hi, zero, div_by_zero,
//             illegal_op
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [3:0]         aluco;
    logic [WIDTH-1:0]   aluin1;
    logic [WIDTH-1:0]   aluin2;
    logic [SHAMT_W-1:0] alu_shift;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   aluout;
    logic [WIDTH-1:0]   aluout_hi;
    logic               zero;
    logic               div_by_zero;
    logic               illegal_op;

    modport master (
        output in_valid, aluco, aluin1, aluin2, alu_shift, out_ready,
        input  in_ready, out_valid, aluout, aluout_hi, zero, div_by_zero, illegal_op
    );

    modport slave (
        input  in_valid, aluco, aluin1, aluin2, alu_shift, out_ready,
        output in_ready, out_valid, aluout, aluout_hi, zero, div_by_zero, illegal_op
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked MIPS EX-stage ALU. Single-cycle logic/arith/shift/compare
// ops return in one cycle; MULU (shift-add) and DIVU (restoring) iterate one
// bit per cycle for WIDTH cycles. Results are held until the consumer accepts.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : alu_seq_if.slave (request/response handshake, operands, results, flags)
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_SRL = 4'd3,
        OP_SRA  = 4'd4,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7,  OP_MULU = 4'd8,
        OP_SLTU = 4'd9,  OP_DIVU = 4'd10, OP_NOR  = 4'd12, OP_SLL = 4'd14
    } op_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (MULU) or divisor (DIVU)
    logic [WIDTH-1:0]   lo_q, lo_d;         // multiplier/product-low or dividend/quotient
    logic [WIDTH-1:0]   hi_q, hi_d;         // partial product-high or partial remainder
    logic               out_valid_q, out_valid_d;
    logic               zero_q, zero_d;
    logic               dbz_q, dbz_d;
    logic               ill_q, ill_d;

    logic               accept;
    logic               is_iter;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ill;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_iter      = (bus.aluco == OP_MULU) || (bus.aluco == OP_DIVU);

    // Single-cycle result for the opcode currently on the bus.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sc_res = '0;
        sc_ill = 1'b0;
        case (bus.aluco)
            OP_AND:  sc_res = bus.aluin1 & bus.aluin2;
            OP_OR:   sc_res = bus.aluin1 | bus.aluin2;
            OP_NOR:  sc_res = ~(bus.aluin1 | bus.aluin2);
            OP_ADD:  sc_res = bus.aluin1 + bus.aluin2;
            OP_SUB:  sc_res = bus.aluin1 - bus.aluin2;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.aluin1) < $signed(bus.aluin2))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.aluin1 < bus.aluin2)};
            OP_SLL:  sc_res = bus.aluin2 << bus.alu_shift;
            OP_SRL:  sc_res = bus.aluin2 >> bus.alu_shift;
            OP_SRA:  sc_res = $signed(bus.aluin2) >>> bus.alu_shift;
            OP_MULU, OP_DIVU: sc_res = '0;   // handled by the iterative path
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        opnd_d      = opnd_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        mul_sum     = '0;
        div_shift   = '0;
        div_diff    = '0;

        case (state_q)
            ST_BUSY: begin
                if (is_div_q) begin
                    // Restoring step: bring in the next dividend bit, subtract if it fits.
                    // A zero divisor always "fits", yielding all-ones quotient and rem = A.
                    div_shift = {hi_q, lo_q[WIDTH-1]};
                    div_diff  = div_shift - {1'b0, opnd_q};
                    if (!div_diff[WIDTH]) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add step: {hi,lo} shifts right, multiplier bits leave from lo[0].
                    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
                    hi_d    = mul_sum[WIDTH:1];
                    lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    zero_d  = (lo_d == '0);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready && !bus.in_valid) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // A new op overrides whatever IDLE/HOLD would have done this cycle.
        if (accept) begin
            ill_d = 1'b0;
            dbz_d = 1'b0;
            if (is_iter) begin
                state_d  = ST_BUSY;
                cnt_d    = CNT_W'(WIDTH);
                is_div_d = (bus.aluco == OP_DIVU);
                opnd_d   = (bus.aluco == OP_DIVU) ? bus.aluin2 : bus.aluin1;
                lo_d     = (bus.aluco == OP_DIVU) ? bus.aluin1 : bus.aluin2;
                hi_d     = '0;
                zero_d   = 1'b0;
                dbz_d    = (bus.aluco == OP_DIVU) && (bus.aluin2 == '0);
            end else begin
                state_d = ST_HOLD;
                lo_d    = sc_res;
                hi_d    = '0;
                zero_d  = (sc_res == '0);
                ill_d   = sc_ill;
            end
        end

        // out_valid is its own flop so the consumer sees a clean registered strobe.
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            opnd_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            opnd_q      <= opnd_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.aluout      = lo_q;
    assign bus.aluout_hi   = hi_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal_op  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;
    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SRL = 4'd3,
                           OP_SRA = 4'd4, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_MULU = 4'd8,
                           OP_SLTU = 4'd9, OP_DIVU = 4'd10, OP_NOR = 4'd12, OP_SLL = 4'd14;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst8 = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus  ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
        logic        z;
        logic        ill;
    } vec_t;

    // Issue one op from a negedge and wait (bounded) for out_valid.
    // lat counts negedges after the accepting edge; rdy_bad flags in_ready=1 while busy.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int limit, output int lat, output bit rdy_bad);
        bus.aluco = op; bus.aluin1 = a; bus.aluin2 = b; bus.alu_shift = sh;
        bus.in_valid = 1'b1;
        lat = 0; rdy_bad = 1'b0;
        @(posedge clk);
        while (lat < limit) begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            if (bus.out_valid) break;
            if (bus.in_ready) rdy_bad = 1'b1;
        end
    endtask

    task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int limit, output int lat, output bit rdy_bad);
        bus8.aluco = op; bus8.aluin1 = a; bus8.aluin2 = b; bus8.alu_shift = '0;
        bus8.in_valid = 1'b1;
        lat = 0; rdy_bad = 1'b0;
        @(posedge clk);
        while (lat < limit) begin
            @(negedge clk);
            lat++;
            bus8.in_valid = 1'b0;
            if (bus8.out_valid) break;
            if (bus8.in_ready) rdy_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.aluout !== 32'h0) begin errors++; $display("FAIL reset aluout got=%h want=0", bus.aluout); end
        checks++; if (bus.aluout_hi !== 32'h0) begin errors++; $display("FAIL reset aluout_hi got=%h want=0", bus.aluout_hi); end
        checks++; if ({bus.zero, bus.div_by_zero, bus.illegal_op} !== 3'b000) begin errors++;
            $display("FAIL reset flags got=%b want=000", {bus.zero, bus.div_by_zero, bus.illegal_op}); end
        checks++; if ({bus8.out_valid, bus8.aluout, bus8.aluout_hi} !== 17'h0) begin errors++;
            $display("FAIL reset8 outputs got=%h want=0", {bus8.out_valid, bus8.aluout, bus8.aluout_hi}); end
        rst = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset8 in_ready got=%b want=1", bus8.in_ready); end
    endtask

    task automatic test_single_cycle();
        vec_t v [14];
        v = '{
            '{OP_ADD,  32'h8,        32'h4,        5'd0,  32'hC,        1'b0, 1'b0},
            '{OP_SUB,  32'h8,        32'h4,        5'd0,  32'h4,        1'b0, 1'b0},
            '{OP_AND,  32'h8,        32'h4,        5'd0,  32'h0,        1'b1, 1'b0},
            '{OP_NOR,  32'h8,        32'h4,        5'd0,  32'hFFFFFFF3, 1'b0, 1'b0},
            '{OP_OR,   32'h8,        32'h4,        5'd0,  32'hC,        1'b0, 1'b0},
            '{OP_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0},
            '{OP_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0},
            '{OP_SRA,  32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{OP_SRL,  32'h0,        32'h80000000, 5'd31, 32'h1,        1'b0, 1'b0},
            '{OP_SLL,  32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0},
            '{4'd5,    32'h8,        32'h4,        5'd0,  32'h0,        1'b1, 1'b1},
            '{OP_ADD,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0},
            '{OP_SUB,  32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0},
            '{4'd15,   32'h8,        32'h4,        5'd3,  32'h0,        1'b1, 1'b1}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.aluco = v[i].op; bus.aluin1 = v[i].a; bus.aluin2 = v[i].b; bus.alu_shift = v[i].sh;
            bus.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.aluout !== v[i].exp || bus.aluout_hi !== 32'h0) begin
                errors++;
                $display("FAIL single[%0d] op=%0d valid/lo/hi got=%b/%h/%h want=1/%h/0",
                         i, v[i].op, bus.out_valid, bus.aluout, bus.aluout_hi, v[i].exp);
            end
            checks++; if (bus.zero !== v[i].z || bus.illegal_op !== v[i].ill) begin
                errors++;
                $display("FAIL single[%0d] zero/illegal got=%b/%b want=%b/%b",
                         i, bus.zero, bus.illegal_op, v[i].z, v[i].ill);
            end
            checks++; if (bus.in_ready !== 1'b1) begin errors++;
                $display("FAIL single[%0d] in_ready got=%b want=1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mulu();
        int lat; bit rb;
        do_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 100, lat, rb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulu_max latency got=%0d want=33", lat); end
        checks++; if (rb !== 1'b0) begin errors++; $display("FAIL mulu_max in_ready_busy got=1 want=0"); end
        checks++; if (bus.aluout_hi !== 32'hFFFFFFFE || bus.aluout !== 32'h1) begin errors++;
            $display("FAIL mulu_max hi/lo got=%h/%h want=fffffffe/00000001", bus.aluout_hi, bus.aluout); end
        checks++; if ({bus.zero, bus.illegal_op, bus.div_by_zero} !== 3'b000) begin errors++;
            $display("FAIL mulu_max flags got=%b want=000", {bus.zero, bus.illegal_op, bus.div_by_zero}); end
        // accepted straight out of HOLD
        do_op(OP_MULU, 32'h12345678, 32'h10, 5'd0, 100, lat, rb);
        checks++; if (lat !== 33 || bus.aluout_hi !== 32'h1 || bus.aluout !== 32'h23456780) begin errors++;
            $display("FAIL mulu_b2b lat/hi/lo got=%0d/%h/%h want=33/00000001/23456780", lat, bus.aluout_hi, bus.aluout); end
        do_op(OP_MULU, 32'h0, 32'h5, 5'd0, 100, lat, rb);
        checks++; if (bus.aluout !== 32'h0 || bus.aluout_hi !== 32'h0 || bus.zero !== 1'b1) begin errors++;
            $display("FAIL mulu_zero hi/lo/zero got=%h/%h/%b want=0/0/1", bus.aluout_hi, bus.aluout, bus.zero); end
    endtask

    task automatic test_divu();
        int lat; bit rb;
        do_op(OP_DIVU, 32'd100, 32'd7, 5'd0, 100, lat, rb);
        checks++; if (lat !== 33 || rb !== 1'b0) begin errors++;
            $display("FAIL divu latency/rdy got=%0d/%b want=33/0", lat, rb); end
        checks++; if (bus.aluout !== 32'd14 || bus.aluout_hi !== 32'd2 || bus.div_by_zero !== 1'b0) begin errors++;
            $display("FAIL divu q/r/dbz got=%h/%h/%b want=e/2/0", bus.aluout, bus.aluout_hi, bus.div_by_zero); end
        do_op(OP_DIVU, 32'd5, 32'd0, 5'd0, 100, lat, rb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu0 latency got=%0d want=33", lat); end
        checks++; if (bus.aluout !== 32'hFFFFFFFF || bus.aluout_hi !== 32'd5 || bus.div_by_zero !== 1'b1 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL divu0 q/r/dbz/zero got=%h/%h/%b/%b want=ffffffff/5/1/0",
                     bus.aluout, bus.aluout_hi, bus.div_by_zero, bus.zero);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit rb; bit unstable;
        @(posedge clk);          // out_ready=1, in_valid=0: HOLD -> IDLE
        @(negedge clk);
        bus.out_ready = 1'b0;
        do_op(OP_ADD, 32'h8, 32'h4, 5'd0, 5, lat, rb);
        checks++; if (lat !== 1 || bus.aluout !== 32'hC || bus.div_by_zero !== 1'b0) begin errors++;
            $display("FAIL bp_first lat/lo/dbz got=%0d/%h/%b want=1/c/0", lat, bus.aluout, bus.div_by_zero); end
        bus.aluco = OP_SUB; bus.aluin1 = 32'h8; bus.aluin2 = 32'h4; bus.in_valid = 1'b1;
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.aluout !== 32'hC || bus.aluout_hi !== 32'h0 || bus.in_ready !== 1'b0)
                unstable = 1'b1;
        end
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_hold stable got=changed want=stable"); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%b want=1", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.aluout !== 32'h4) begin errors++;
            $display("FAIL bp_next valid/lo got=%b/%h want=1/4", bus.out_valid, bus.aluout); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_mulu();
        int lat; bit rb; bit rose;
        bus.aluco = OP_MULU; bus.aluin1 = 32'hFFFFFFFF; bus.aluin2 = 32'hFFFFFFFF; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({bus.out_valid, bus.aluout, bus.aluout_hi, bus.zero, bus.div_by_zero, bus.illegal_op} !== 68'h0) begin
            errors++;
            $display("FAIL rst_mid outputs got=%b/%h/%h want=0/0/0", bus.out_valid, bus.aluout, bus.aluout_hi);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got=%b want=1", bus.in_ready); end
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=rose want=never"); end
        do_op(OP_ADD, 32'h3, 32'h5, 5'd0, 5, lat, rb);
        checks++; if (lat !== 1 || bus.aluout !== 32'h8 || bus.aluout_hi !== 32'h0) begin errors++;
            $display("FAIL rst_mid add lat/lo/hi got=%0d/%h/%h want=1/8/0", lat, bus.aluout, bus.aluout_hi); end
    endtask

    task automatic test_width8();
        int lat; bit rb; bit rose;
        bus8.out_ready = 1'b1;
        do_op8(OP_MULU, 8'hFF, 8'hFF, 40, lat, rb);
        checks++; if (lat !== 9 || rb !== 1'b0) begin errors++; $display("FAIL w8_mulu lat/rdy got=%0d/%b want=9/0", lat, rb); end
        checks++; if (bus8.aluout_hi !== 8'hFE || bus8.aluout !== 8'h01) begin errors++;
            $display("FAIL w8_mulu hi/lo got=%h/%h want=fe/01", bus8.aluout_hi, bus8.aluout); end
        do_op8(OP_DIVU, 8'd200, 8'd9, 40, lat, rb);
        checks++; if (lat !== 9 || bus8.aluout !== 8'd22 || bus8.aluout_hi !== 8'd2) begin errors++;
            $display("FAIL w8_divu lat/q/r got=%0d/%h/%h want=9/16/02", lat, bus8.aluout, bus8.aluout_hi); end
        // reset partway through a MULU
        bus8.aluco = OP_MULU; bus8.aluin1 = 8'hFF; bus8.aluin2 = 8'hFF; bus8.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        #1;
        checks++; if ({bus8.out_valid, bus8.aluout, bus8.aluout_hi, bus8.zero, bus8.div_by_zero, bus8.illegal_op} !== 20'h0) begin
            errors++;
            $display("FAIL w8_rst outputs got=%b/%h/%h want=0/0/0", bus8.out_valid, bus8.aluout, bus8.aluout_hi);
        end
        @(negedge clk);
        rst8 = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.out_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0) begin errors++; $display("FAIL w8_rst out_valid got=rose want=never"); end
        do_op8(OP_ADD, 8'hF0, 8'h20, 5, lat, rb);
        checks++; if (lat !== 1 || bus8.aluout !== 8'h10 || bus8.zero !== 1'b0) begin errors++;
            $display("FAIL w8_add lat/lo/zero got=%0d/%h/%b want=1/10/0", lat, bus8.aluout, bus8.zero); end
    endtask

    initial begin
        bus.in_valid  = 1'b0; bus.aluco  = '0; bus.aluin1  = '0; bus.aluin2  = '0; bus.alu_shift  = '0; bus.out_ready  = 1'b1;
        bus8.in_valid = 1'b0; bus8.aluco = '0; bus8.aluin1 = '0; bus8.aluin2 = '0; bus8.alu_shift = '0; bus8.out_ready = 1'b1;
        test_reset();
        test_single_cycle();
        test_mulu();
        test_divu();
        test_backpressure();
        test_reset_mid_mulu();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
